rv32i_regfile_fwd: RTL
======================

RV32I_REGFILE_FWD -- requirements
Module: rv32i_regfile_fwd

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  system clock, rising edge; reset  in  1  reset, synchronous, active-high.
REQ-002 SHALL have writeback port: wb_en  in  1  write enable; wb_reg  in  5  destination register; wb_data  in  32  write data.
REQ-003 SHALL have decode read request: rs_valid  in  1  request valid; rs1_reg  in  5  source 1; rs2_reg  in  5  source 2.
REQ-004 SHALL have EX forward inputs: df_ex_enable  in  1; df_ex_reg  in  5; df_ex_data  in  32; df_ex_is_load  in  1  EX op is a load, data not ready.
REQ-005 SHALL have MEM forward inputs: df_mem_enable  in  1; df_mem_reg  in  5; df_mem_data  in  32; df_mem_is_load  in  1  MEM op is a load, data not ready.
REQ-006 SHALL have WB forward inputs: df_wb_enable  in  1; df_wb_reg  in  5; df_wb_data  in  32.
REQ-007 SHALL have outputs: rs1_data  out  32  registered operand 1; rs2_data  out  32  registered operand 2; rs_valid_out  out  1  operands valid; stall  out  1  combinational load-use stall to decode; stall_count  out  16  saturating stall-cycle count.

Function
REQ-008 SHALL hold 31 x 32-bit registers x1..x31; x0 SHALL read 0, and writes to x0 SHALL be ignored.
REQ-009 SHALL write wb_data to wb_reg on the rising clk edge when wb_en=1 and reset=0.
REQ-010 SHALL resolve each operand with priority EX > MEM > WB > register array; a source matches only if its enable=1, its reg equals the operand reg, and the operand reg is nonzero.
REQ-011 SHALL assert stall in the same cycle when rs_valid=1 and the winning match for either operand is EX with df_ex_is_load=1 or MEM with df_mem_is_load=1.
REQ-012 SHALL register operands with 1-cycle latency: on a cycle with rs_valid=1 and stall=0, rs1_data/rs2_data SHALL load the resolved values and rs_valid_out SHALL be 1 the next cycle.
REQ-013 SHALL emit a bubble when stall=1 or rs_valid=0: rs_valid_out=0 next cycle and rs1_data/rs2_data unchanged.
REQ-014 SHALL use the write data on a same-cycle WB write and read of the same register via the df_wb/wb_data path, never the stale array value.
REQ-015 SHALL drop stall when the load leaves MEM, so a load-use costs at most 2 stall cycles (EX then MEM) and releases on the WB forward.
REQ-016 SHALL increment stall_count by 1 each cycle stall=1 and saturate at 16'hFFFF without wrapping.

Reset
REQ-017 SHALL, with reset=1 at a clock edge, clear x1..x31, rs1_data, rs2_data, rs_valid_out and stall_count to 0.
REQ-018 SHALL ignore wb_en during reset; stall SHALL be forced to 0 while reset=1.
REQ-019 SHALL, on reset mid-stall, drop the stall and resume with clean state on the first cycle after reset deasserts.

Configuration
REQ-020 SHALL include the stall counter only when macro RV32I_RF_STALL_CNT_EN is defined; otherwise stall_count SHALL be tied to 0, no counter flops SHALL be built, and all other behaviour SHALL be unchanged.

Structure
REQ-021 SHALL take XLEN=32, REG_ADDR_W=5, STALL_CNT_W=16 and enum fwd_src_e {FWD_RF, FWD_WB, FWD_MEM, FWD_EX} from shared package rv32i_pkg.
REQ-022 SHALL implement per-operand priority selection and load-hazard detection in sub-module rv32i_fwd_mux, instanced twice.

Verification
REQ-023 SHALL cover: write x5=0x1234_5678 via WB, then read rs1=x5 with no forwards -> rs1_data=0x1234_5678 one cycle later.
REQ-024 SHALL cover: wb_en=1, wb_reg=0, wb_data=0xFFFF_FFFF, then read x0 -> rs1_data=0.
REQ-025 SHALL cover: EX x7=0xA, MEM x7=0xB, WB x7=0xC all enabled, read rs2=x7 -> rs2_data=0xA.
REQ-026 SHALL cover: EX load to x3 (df_ex_is_load=1), rs1=x3 held with rs_valid=1 -> stall=1 for 2 cycles, rs_valid_out=0 for those cycles, then WB forward 0x55 gives rs1_data=0x55, stall_count=2.
REQ-027 SHALL cover: reset asserted during a stall -> stall=0, all outputs 0 next cycle; with RV32I_RF_STALL_CNT_EN undefined, stall_count stays 0 through REQ-026.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file/forwarding types and widths.
package rv32i_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned NUM_REGS    = 32;

    // Operand source, in ascending priority order.
    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_src_e;

    // One pipeline-stage forward payload.
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic                  is_load;
    } fwd_bus_t;

    // A source matches only when enabled, same register, and not x0.
    function automatic logic fwd_hit(input logic en,
                                     input logic [REG_ADDR_W-1:0] src_reg,
                                     input logic [REG_ADDR_W-1:0] op_reg);
        return en && (src_reg == op_reg) && (op_reg != '0);
    endfunction

endpackage

// File: rtl/rv32i_fwd_mux.sv
// Per-operand forwarding select (EX > MEM > WB > RF) and load-use hazard detect.
module rv32i_fwd_mux
    import rv32i_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] op_reg_i,
    input  fwd_bus_t              ex_i,
    input  fwd_bus_t              mem_i,
    input  logic                  wb_en_i,
    input  logic [REG_ADDR_W-1:0] wb_reg_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic [XLEN-1:0]       rf_data_i,
    output logic [XLEN-1:0]       data_c_o,
    output logic                  load_hazard_c_o
);

    fwd_src_e src;

    // Pick the winning source; later checks override earlier ones.
    always_comb begin
        src = FWD_RF;
        if (fwd_hit(wb_en_i, wb_reg_i, op_reg_i))     src = FWD_WB;
        if (fwd_hit(mem_i.en, mem_i.rd, op_reg_i))    src = FWD_MEM;
        if (fwd_hit(ex_i.en, ex_i.rd, op_reg_i))      src = FWD_EX;
    end

    // Route data; a winning load means the value is not available yet.
    always_comb begin
        data_c_o        = rf_data_i;
        load_hazard_c_o = 1'b0;
        unique case (src)
            FWD_EX: begin
                data_c_o        = ex_i.data;
                load_hazard_c_o = ex_i.is_load;
            end
            FWD_MEM: begin
                data_c_o        = mem_i.data;
                load_hazard_c_o = mem_i.is_load;
            end
            FWD_WB:  data_c_o = wb_data_i;
            FWD_RF:  data_c_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/rv32i_regfile_fwd.sv
// RV32I register file with EX/MEM/WB forwarding, load-use stall and
// registered operand outputs. Optional stall counter: RV32I_RF_STALL_CNT_EN.
module rv32i_regfile_fwd
    import rv32i_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_en,
    input  logic [REG_ADDR_W-1:0]  wb_reg,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   rs_valid,
    input  logic [REG_ADDR_W-1:0]  rs1_reg,
    input  logic [REG_ADDR_W-1:0]  rs2_reg,
    input  logic                   df_ex_enable,
    input  logic [REG_ADDR_W-1:0]  df_ex_reg,
    input  logic [XLEN-1:0]        df_ex_data,
    input  logic                   df_ex_is_load,
    input  logic                   df_mem_enable,
    input  logic [REG_ADDR_W-1:0]  df_mem_reg,
    input  logic [XLEN-1:0]        df_mem_data,
    input  logic                   df_mem_is_load,
    input  logic                   df_wb_enable,
    input  logic [REG_ADDR_W-1:0]  df_wb_reg,
    input  logic [XLEN-1:0]        df_wb_data,
    output logic [XLEN-1:0]        rs1_data,
    output logic [XLEN-1:0]        rs2_data,
    output logic                   rs_valid_out,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [XLEN-1:0] regs_q [1:NUM_REGS-1];
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic            rs_valid_out_q, rs_valid_out_d;
    logic [XLEN-1:0] rf1, rf2;
    logic [XLEN-1:0] op1, op2;
    logic            haz1, haz2;
    fwd_bus_t        ex_bus, mem_bus;

    // Pack stage forwards into bus payloads.
    always_comb begin
        ex_bus.en       = df_ex_enable;
        ex_bus.rd       = df_ex_reg;
        ex_bus.data     = df_ex_data;
        ex_bus.is_load  = df_ex_is_load;
        mem_bus.en      = df_mem_enable;
        mem_bus.rd      = df_mem_reg;
        mem_bus.data    = df_mem_data;
        mem_bus.is_load = df_mem_is_load;
    end

    // Array read with x0 hardwired and same-cycle write bypass.
    always_comb begin
        rf1 = '0;
        rf2 = '0;
        if (rs1_reg != '0) rf1 = regs_q[rs1_reg];
        if (rs2_reg != '0) rf2 = regs_q[rs2_reg];
        if (fwd_hit(wb_en, wb_reg, rs1_reg)) rf1 = wb_data;
        if (fwd_hit(wb_en, wb_reg, rs2_reg)) rf2 = wb_data;
    end

    rv32i_fwd_mux u_fwd_rs1 (
        .op_reg_i        (rs1_reg),
        .ex_i            (ex_bus),
        .mem_i           (mem_bus),
        .wb_en_i         (df_wb_enable),
        .wb_reg_i        (df_wb_reg),
        .wb_data_i       (df_wb_data),
        .rf_data_i       (rf1),
        .data_c_o        (op1),
        .load_hazard_c_o (haz1)
    );

    rv32i_fwd_mux u_fwd_rs2 (
        .op_reg_i        (rs2_reg),
        .ex_i            (ex_bus),
        .mem_i           (mem_bus),
        .wb_en_i         (df_wb_enable),
        .wb_reg_i        (df_wb_reg),
        .wb_data_i       (df_wb_data),
        .rf_data_i       (rf2),
        .data_c_o        (op2),
        .load_hazard_c_o (haz2)
    );

    // Load-use stall back to decode; reset masks it.
    assign stall = !reset && rs_valid && (haz1 || haz2);

    // Register array; x0 has no storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_en && (wb_reg != '0)) begin
            regs_q[wb_reg] <= wb_data;
        end
    end

    // Operand capture on accepted requests, bubble otherwise.
    always_comb begin
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        rs_valid_out_d = 1'b0;
        if (rs_valid && !stall) begin
            rs1_data_d     = op1;
            rs2_data_d     = op2;
            rs_valid_out_d = 1'b1;
        end
    end

    // Operand output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            rs_valid_out_q <= 1'b0;
        end else begin
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            rs_valid_out_q <= rs_valid_out_d;
        end
    end

    assign rs1_data     = rs1_data_q;
    assign rs2_data     = rs2_data_q;
    assign rs_valid_out = rs_valid_out_q;

`ifdef RV32I_RF_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule
